irrigation_timer: RTL

- BCD countdown timer (MM:SS) that times one irrigation cycle.
- Loads the preset duration when the timer reset pulse arrives from the reseter logic.
- Counts down once per second while irrigation runs and reports expiry.
- Drives the minutes_d / minutes_u / seconds_d digits consumed by the reset logic, plus seconds_u for the display.

---
 rtl/irrigation_timer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/irrigation_timer.sv
// irrigation_timer: BCD MM:SS countdown timer for one irrigation cycle.
// A load pulse captures the (clamped) preset minutes with seconds 00. The
// count then decrements once per prescaled one-second tick while enabled,
// holds while paused, and latches EXPIRED when it reaches 00:00.
module irrigation_timer #(
    parameter int unsigned TICK_DIVIDER  = 50000000,
    parameter int unsigned MAX_MINUTES_D = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       timer_reset,
    input  logic       count_enable,
    input  logic [1:0] preset_minutes_d,
    input  logic [3:0] preset_minutes_u,
    output logic [1:0] minutes_d,
    output logic [3:0] minutes_u,
    output logic [2:0] seconds_d,
    output logic [3:0] seconds_u,
    output logic       running,
    output logic       timer_done,
    output logic       done_pulse,
    output logic       preset_clamped
);

    localparam int unsigned PW        = $clog2(TICK_DIVIDER);
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIVIDER - 1);
    localparam logic [1:0]    MD_MAX    = 2'(MAX_MINUTES_D);

    typedef enum logic [1:0] {
        IDLE,
        RUNNING,
        PAUSED,
        EXPIRED
    } state_t;

    typedef struct packed {
        logic [1:0] md;
        logic [3:0] mu;
        logic [2:0] sd;
        logic [3:0] su;
    } bcd_time_t;

    state_t    state;
    bcd_time_t cnt;
    bcd_time_t cnt_dec;
    bcd_time_t load_val;
    logic [PW-1:0] prescaler;
    logic      load_clamp;
    logic      load_zero;
    logic      dec_zero;

    // One-second BCD decrement with borrow through every digit.
    function automatic bcd_time_t dec_time(input bcd_time_t t);
        bcd_time_t r;
        r = t;
        if (t.su != 4'd0) begin
            r.su = t.su - 4'd1;
        end else begin
            r.su = 4'd9;
            if (t.sd != 3'd0) begin
                r.sd = t.sd - 3'd1;
            end else begin
                r.sd = 3'd5;
                if (t.mu != 4'd0) begin
                    r.mu = t.mu - 4'd1;
                end else begin
                    r.mu = 4'd9;
                    r.md = t.md - 2'd1;
                end
            end
        end
        return r;
    endfunction

    // Preset clamping and the decremented value feeding the state register.
    always_comb begin
        load_val    = '0;
        load_clamp  = 1'b0;
        load_val.mu = (preset_minutes_u > 4'd9) ? 4'd9 : preset_minutes_u;
        load_val.md = (preset_minutes_d > MD_MAX) ? MD_MAX : preset_minutes_d;
        load_clamp  = (preset_minutes_u > 4'd9) || (preset_minutes_d > MD_MAX);
        load_zero   = (load_val == '0);
        cnt_dec     = dec_time(cnt);
        dec_zero    = (cnt_dec == '0);
    end

    // Timer FSM: load, prescale, decrement and registered status outputs.
    // NOTE: every register here uses <= so all state updates at one edge see
    // the pre-edge values; blocking assignments would chain them in order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            prescaler      <= '0;
            running        <= 1'b0;
            timer_done     <= 1'b0;
            done_pulse     <= 1'b0;
            preset_clamped <= 1'b0;
        end else begin
            done_pulse     <= 1'b0;
            preset_clamped <= 1'b0;
            if (timer_reset) begin
                cnt            <= load_val;
                prescaler      <= '0;
                preset_clamped <= load_clamp;
                if (load_zero) begin
                    state      <= EXPIRED;
                    running    <= 1'b0;
                    timer_done <= 1'b1;
                    done_pulse <= 1'b1;
                end else if (count_enable) begin
                    state      <= RUNNING;
                    running    <= 1'b1;
                    timer_done <= 1'b0;
                end else begin
                    state      <= PAUSED;
                    running    <= 1'b0;
                    timer_done <= 1'b0;
                end
            end else begin
                case (state)
                    IDLE: begin
                        // Frozen until a load arrives; enable has no effect.
                    end
                    RUNNING: begin
                        if (!count_enable) begin
                            state   <= PAUSED;
                            running <= 1'b0;
                        end else if (prescaler == TICK_LAST) begin
                            prescaler <= '0;
                            cnt       <= cnt_dec;
                            if (dec_zero) begin
                                state      <= EXPIRED;
                                running    <= 1'b0;
                                timer_done <= 1'b1;
                                done_pulse <= 1'b1;
                            end
                        end else begin
                            prescaler <= prescaler + PW'(1);
                        end
                    end
                    PAUSED: begin
                        if (count_enable) begin
                            state   <= RUNNING;
                            running <= 1'b1;
                        end
                    end
                    EXPIRED: begin
                        // Sits at 00:00 until a load or reset.
                    end
                    default: begin
                        state   <= IDLE;
                        running <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign minutes_d = cnt.md;
    assign minutes_u = cnt.mu;
    assign seconds_d = cnt.sd;
    assign seconds_u = cnt.su;

endmodule
